// File: rtl/prog_timer.sv
// prog_timer: programmable down-counting timer with prescaler, one-shot/periodic modes,
// one-cycle done pulses and a sticky expired flag.
module prog_timer #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_expired,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, EXPIRED = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] lat_l;
    logic             lat_mode;
    logic             run_en, ptick, expiry;

    assign busy   = state == RUN;
    assign run_en = busy && en;
    assign ptick  = run_en && pre == PMAX;
    assign expiry = ptick && count == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pre      <= '0;
            count    <= '0;
            lat_l    <= '0;
            lat_mode <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
        end else if (stop) begin
            state   <= IDLE;
            pre     <= '0;
            count   <= '0;
            done    <= 1'b0;
            expired <= expired & ~clr_expired;
        end else if (start) begin
            // a restart drops any expiry that would have landed this cycle
            lat_l    <= load_val;
            lat_mode <= mode;
            state    <= RUN;
            count    <= load_val;
            pre      <= '0;
            done     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            done    <= expiry;
            expired <= expiry | (expired & ~clr_expired);
            if (run_en)
                pre <= ptick ? '0 : pre + PW'(1);
            if (ptick)
                count <= (count != '0) ? count - WIDTH'(1) : (lat_mode ? lat_l : count);
            if (expiry && !lat_mode)
                state <= EXPIRED;
        end
    end
endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed scoreboard bench; dut_a uses WIDTH=8/PRESCALE=3, dut_b WIDTH=4/PRESCALE=1.
module tb_prog_timer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a = 1'b1, en_a = 1'b1, st_a = 1'b0, sp_a = 1'b0, mode_a = 1'b0, clr_a = 1'b0;
    logic [7:0] load_a = '0, count_a;
    logic       busy_a, done_a, expired_a;
    logic       rst_b = 1'b1, en_b = 1'b1, st_b = 1'b0, sp_b = 1'b0, mode_b = 1'b0, clr_b = 1'b0;
    logic [3:0] load_b = '0, count_b;
    logic       busy_b, done_b, expired_b;

    prog_timer #(.WIDTH(8), .PRESCALE(3)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .start(st_a), .stop(sp_a), .mode(mode_a),
        .load_val(load_a), .clr_expired(clr_a), .count(count_a), .busy(busy_a),
        .done(done_a), .expired(expired_a)
    );
    prog_timer #(.WIDTH(4), .PRESCALE(1)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .start(st_b), .stop(sp_b), .mode(mode_b),
        .load_val(load_b), .clr_expired(clr_b), .count(count_b), .busy(busy_b),
        .done(done_b), .expired(expired_b)
    );

    typedef struct {int id; int cyc; int cnt; logic bsy; logic exp;} chk_t;
    chk_t chk_q[$];
    int   dq_a[$], dq_b[$];
    int   vectors = 0, miscompares = 0;
    int   act_cnt, want_done;
    logic act_bsy, act_exp;
    logic draining = 1'b0, drained = 1'b0;

    // scoreboard monitor: state checks fire on their cycle, every done pulse pops a queue
    always @(negedge clk) begin
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
                act_cnt = chk_q[i].id ? int'(count_b) : int'(count_a);
                act_bsy = chk_q[i].id ? busy_b : busy_a;
                act_exp = chk_q[i].id ? expired_b : expired_a;
                vectors++;
                if (act_cnt != chk_q[i].cnt || act_bsy !== chk_q[i].bsy || act_exp !== chk_q[i].exp) begin
                    miscompares++;
                    $display("FAIL state dut%0d cyc %0d: count=%0d busy=%b expired=%b, want count=%0d busy=%b expired=%b",
                             chk_q[i].id, cyc, act_cnt, act_bsy, act_exp, chk_q[i].cnt, chk_q[i].bsy, chk_q[i].exp);
                end
                chk_q.delete(i);
            end
        end
        if (done_a) begin
            vectors++;
            want_done = dq_a.size() ? dq_a.pop_front() : -1;
            if (want_done != cyc) begin
                miscompares++;
                $display("FAIL done dut0: pulse at cyc %0d, want cyc %0d", cyc, want_done);
            end
        end
        if (done_b) begin
            vectors++;
            want_done = dq_b.size() ? dq_b.pop_front() : -1;
            if (want_done != cyc) begin
                miscompares++;
                $display("FAIL done dut1: pulse at cyc %0d, want cyc %0d", cyc, want_done);
            end
        end
        if (draining && !drained) begin
            foreach (dq_a[i]) begin vectors++; miscompares++; $display("FAIL missed done dut0: no pulse, want cyc %0d", dq_a[i]); end
            foreach (dq_b[i]) begin vectors++; miscompares++; $display("FAIL missed done dut1: no pulse, want cyc %0d", dq_b[i]); end
            foreach (chk_q[i]) begin vectors++; miscompares++; $display("FAIL unchecked state dut%0d: not reached, want cyc %0d", chk_q[i].id, chk_q[i].cyc); end
            drained = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input int id, input int c, input int cnt, input logic b, input logic e);
        chk_t x;
        x = '{id, c, cnt, b, e};
        chk_q.push_back(x);
    endtask

    task automatic go_a(input int l, input logic m, output int t);
        load_a = 8'(l); mode_a = m; st_a = 1'b1;
        step(1);
        st_a = 1'b0; t = cyc;
    endtask

    task automatic go_b(input int l, input logic m, output int t);
        load_b = 4'(l); mode_b = m; st_b = 1'b1;
        step(1);
        st_b = 1'b0; t = cyc;
    endtask

    int t, t2;
    initial begin
        step(2);
        rst_a = 1'b0; rst_b = 1'b0;
        expect_state(0, cyc, 0, 0, 0);
        expect_state(1, cyc, 0, 0, 0);
        step(2);
        // reset mid-run
        go_a(10, 0, t);
        step(17);
        expect_state(0, t + 17, 5, 1, 0);
        rst_a = 1'b1; step(1); rst_a = 1'b0;
        expect_state(0, cyc, 0, 0, 0);
        expect_state(0, cyc + 5, 0, 0, 0);
        step(6);
        // one-shot latency
        go_a(4, 0, t);
        dq_a.push_back(t + 15);
        expect_state(0, t + 14, 0, 1, 0);
        expect_state(0, t + 15, 0, 0, 1);
        expect_state(0, t + 115, 0, 0, 1);
        step(116);
        // periodic with en gating
        go_a(2, 1, t);
        expect_state(0, t, 2, 1, 0);
        dq_a.push_back(t + 9); dq_a.push_back(t + 18); dq_a.push_back(t + 32);
        expect_state(0, t + 21, 2, 1, 1);
        expect_state(0, t + 33, 2, 1, 1);
        step(18);
        en_a = 1'b0; step(5); en_a = 1'b1;
        step(11);
        sp_a = 1'b1; step(1); sp_a = 1'b0;
        expect_state(0, cyc, 0, 0, 1);
        step(2);
        // restart mid-run
        go_a(9, 0, t);
        expect_state(0, t, 9, 1, 0);
        step(5);
        go_a(5, 0, t2);
        expect_state(0, t2, 5, 1, 0);
        dq_a.push_back(t2 + 18);
        expect_state(0, t2 + 18, 0, 0, 1);
        step(20);
        // stop and start together
        go_a(3, 1, t);
        step(4);
        sp_a = 1'b1; st_a = 1'b1; load_a = 8'd6;
        step(1);
        sp_a = 1'b0; st_a = 1'b0;
        expect_state(0, cyc, 0, 0, 0);
        expect_state(0, cyc + 3, 0, 0, 0);
        step(4);
        // sticky flag: set beats clear, then clear, then start clears
        go_a(1, 0, t);
        dq_a.push_back(t + 6);
        step(5);
        clr_a = 1'b1; step(1);
        expect_state(0, t + 6, 0, 0, 1);
        step(1); clr_a = 1'b0;
        expect_state(0, t + 7, 0, 0, 0);
        go_a(0, 0, t);
        dq_a.push_back(t + 3);
        expect_state(0, t + 3, 0, 0, 1);
        step(4);
        go_a(2, 0, t);
        expect_state(0, t, 2, 1, 0);
        dq_a.push_back(t + 9);
        step(10);
        // PRESCALE=1, L=0 periodic: done every cycle
        go_b(0, 1, t);
        expect_state(1, t, 0, 1, 0);
        expect_state(1, t + 5, 0, 1, 1);
        for (int i = 1; i <= 10; i++) dq_b.push_back(t + i);
        step(10);
        sp_b = 1'b1; step(1); sp_b = 1'b0;
        expect_state(1, cyc, 0, 0, 1);
        step(2);
        // L = max value, no overflow
        go_b(15, 0, t);
        dq_b.push_back(t + 16);
        expect_state(1, t + 1, 14, 1, 0);
        expect_state(1, t + 15, 0, 1, 0);
        expect_state(1, t + 16, 0, 0, 1);
        step(20);
        draining = 1'b1;
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Parametrised successor to the fixed-terminal tick timer.
- Programmable down-counting timer with a built-in clock prescaler, one-shot and periodic modes, and start/stop/restart control.
- Gives one-cycle `done` pulses and a sticky expiry flag.
- Used wherever the design needs run-time-adjustable delays or periodic ticks: debounce, display refresh, baud/sample strobes.

Parameters:
- WIDTH, 32, width of the load value and the main counter (>=1).
- PRESCALE, 1, clock cycles per counter decrement (>=1). Prescaler width is max(1, $clog2(PRESCALE)). PRESCALE=1 means every enabled cycle is a prescale tick.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable. Low freezes the prescaler and counter; state and outputs are held.
- start  in  1  pulse: latch load_val and mode, begin running.
- stop  in  1  pulse: abort, return to IDLE.
- mode  in  1  0 = one-shot, 1 = periodic. Sampled only on start.
- load_val  in  WIDTH  terminal count L. Sampled only on start.
- clr_expired  in  1  clears the sticky expired flag.
- count  out  WIDTH  current main counter value.
- busy  out  1  high in RUN.
- done  out  1  registered, one-cycle pulse per expiry.
- expired  out  1  sticky; set on every done, cleared by clr_expired/start/rst.

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE; prescaler=0; count=0; latched L=0; latched mode=0.
  - done=0, busy=0, expired=0.
  - rst overrides every other input in the same cycle, including mid-run.
- States: IDLE, RUN, EXPIRED. busy=1 only in RUN.
- Priority each cycle: rst > stop > start > counting.
- stop (any state): next state=IDLE, prescaler=0, count=0, done=0. expired is unchanged. If stop and start are both high, stop wins.
- start (IDLE, RUN or EXPIRED): latch L=load_val and mode. Next cycle: state=RUN, count=L, prescaler=0, expired=0. A start in RUN is a restart, and any pending expiry in that cycle is discarded.
- start is honoured regardless of en.
- Prescale tick ("ptick"): RUN && en && prescaler==PRESCALE-1.
  - On each RUN&&en cycle, prescaler increments, wrapping to 0 on ptick.
- On ptick with count!=0: count decrements by 1.
- On ptick with count==0 (expiry):
  - done=1 next cycle; expired=1 next cycle.
  - Periodic: count reloads L, state stays RUN.
  - One-shot: state goes to EXPIRED, count stays 0.
- Timing with en held high, start sampled at cycle t:
  - First done is in cycle t+1+(L+1)*PRESCALE.
  - Periodic done pulses repeat every (L+1)*PRESCALE cycles exactly, with no slip at reload.
- L=0: expiry on the first ptick, so the period is PRESCALE cycles. With PRESCALE=1 and periodic mode, done is high every cycle.
- L=2^WIDTH-1: no overflow; down-count only.
- en low: cycles do not count toward latency. Timing resumes exactly where it paused.
- done is low in every cycle except the one after an expiry.
- clr_expired: expired=0 next cycle. If it coincides with an expiry, set wins.
- EXPIRED: holds count=0 and done=0 until start or stop.
- stop in IDLE/EXPIRED: goes to IDLE, no other effect.

Test Plan:
- Reset mid-run: PRESCALE=4, L=10, start, run 17 cycles, assert rst 1 cycle -> next cycle count=0, busy=0, done=0, expired=0. Stays IDLE with en=1.
- One-shot latency: PRESCALE=3, L=4, mode=0, en=1, start at t -> single done at t+16, expired=1 from t+16, busy=0 from t+16, count=0. No further done in 100 cycles.
- Periodic + en gating: PRESCALE=2, L=2, mode=1 -> done at t+7, t+13, t+19. Drop en for 5 cycles after t+13 -> next done at t+24.
- Boundaries: PRESCALE=1, L=0, periodic -> done high every cycle from t+2. Then L=2^WIDTH-1 with WIDTH=4, PRESCALE=1 -> done at t+17.
- Restart/stop priority: start, then start again with L=5 mid-run -> count=5 next cycle, first done timed from the second start. stop and start in the same cycle -> IDLE, count=0.
- Sticky flag: one-shot expiry with clr_expired asserted in the expiry cycle -> expired=1. clr_expired next cycle -> expired=0. A new start also clears it.
